// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender behind a 2-entry skid buffer.
//
// The extension is computed combinationally from IN_DATA/IN_OP and captured
// into the output register (or the skid register) when a request is accepted.
// A request accepted while the buffer is empty appears one cycle later.
//
// Modes: 0 zero-extend, 1 sign-extend, 2 upper-load, 3 see below.
// Optional feature macro IMM_BRANCH_SHIFT_EN:
//   defined   -> mode 3 is the branch offset (sign-extend, shift left by 2)
//   undefined -> mode 3 yields OUT_DATA = 0 with OUT_ERR = 1
//
// Ports:
//   CLK        sole clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   request valid
//   IN_DATA    immediate value, IN_W bits
//   IN_OP      extension mode, 2 bits
//   IN_READY   block can accept a request (registered)
//   OUT_VALID  OUT_DATA/OUT_ERR valid (registered)
//   OUT_DATA   extended result, OUT_W bits (registered)
//   OUT_ERR    result came from an unsupported mode (registered)
//   OUT_READY  downstream accepts the result
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic [1:0]       IN_OP,
  output logic             IN_READY,
  output logic             OUT_VALID,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_ERR,
  input  logic             OUT_READY
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic               valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic               out_err_q;
  logic [OUT_W-1:0]   skid_data_q;
  logic               skid_err_q;

  logic [OUT_W-1:0]   sext;
  logic [OUT_W-1:0]   ext_data_d;
  logic               ext_err_d;
  logic               accept;
  logic               consume;

  // Handshake events use the registered ready/valid seen by the neighbours.
  assign accept  = IN_VALID && ready_q;
  assign consume = valid_q && OUT_READY;

  // Extension: bit replication and placement only.
  always_comb begin
    sext       = {{PAD_W{IN_DATA[IN_W-1]}}, IN_DATA};
    ext_data_d = '0;
    ext_err_d  = 1'b0;
    case (IN_OP)
      2'd0:    ext_data_d = {{PAD_W{1'b0}}, IN_DATA};
      2'd1:    ext_data_d = sext;
      2'd2:    ext_data_d = {IN_DATA, {PAD_W{1'b0}}};
      default: begin
`ifdef IMM_BRANCH_SHIFT_EN
        ext_data_d = {sext[OUT_W-3:0], 2'b00};
        ext_err_d  = 1'b0;
`else
        ext_data_d = '0;
        ext_err_d  = 1'b1;
`endif
      end
    endcase
  end

  // Skid-buffer FSM; the head entry lives in out_*_q, the second in skid_*_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_q <= ext_data_d;
            out_err_q  <= ext_err_d;
            valid_q    <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, consume})
            2'b10: begin
              // Head is stalled: park the new entry behind it.
              skid_data_q <= ext_data_d;
              skid_err_q  <= ext_err_d;
              ready_q     <= 1'b0;
              state_q     <= ST_TWO;
            end
            2'b01: begin
              valid_q <= 1'b0;
              state_q <= ST_EMPTY;
            end
            2'b11: begin
              // Head leaves as the new entry arrives.
              out_data_q <= ext_data_d;
              out_err_q  <= ext_err_d;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (consume) begin
            out_data_q <= skid_data_q;
            out_err_q  <= skid_err_q;
            ready_q    <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = ready_q;
  assign OUT_VALID = valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_ERR   = out_err_q;

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; SHALL satisfy 2 <= IN_W < OUT_W.
REQ-002 Parameter OUT_W, default 32, extended output width.
REQ-003 Port CLK, input, 1 bit, sole clock; all state SHALL update on the rising edge.
REQ-004 Port RST, input, 1 bit, reset; SHALL be synchronous and active-high.
REQ-005 Port IN_VALID, input, 1 bit, marks a request on IN_DATA/IN_OP as valid.
REQ-006 Port IN_DATA, input, IN_W bits, immediate value.
REQ-007 Port IN_OP, input, 2 bits, extension mode.
REQ-008 Port IN_READY, output, 1 bit, block can accept a request; SHALL be driven from a register.
REQ-009 Port OUT_VALID, output, 1 bit, marks OUT_DATA/OUT_ERR as valid.
REQ-010 Port OUT_DATA, output, OUT_W bits, extended result.
REQ-011 Port OUT_ERR, output, 1 bit, result produced from an unsupported mode.
REQ-012 Port OUT_READY, input, 1 bit, downstream accepts the result.

Function
REQ-013 A request SHALL be accepted on a cycle where IN_VALID && IN_READY; a result SHALL be consumed on a cycle where OUT_VALID && OUT_READY.
REQ-014 Mode 0, zero-extend: OUT_DATA SHALL be {(OUT_W-IN_W) zeros, IN_DATA}.
REQ-015 Mode 1, sign-extend: OUT_DATA SHALL be {(OUT_W-IN_W) copies of IN_DATA[IN_W-1], IN_DATA}.
REQ-016 Mode 2, upper-load: OUT_DATA SHALL be IN_DATA placed in bits [OUT_W-1 : OUT_W-IN_W], with all lower bits zero.
REQ-017 Mode 3 SHALL follow REQ-036/REQ-037.
REQ-018 OUT_ERR SHALL be 0 for modes 0-2.
REQ-019 Latency SHALL be exactly 1 cycle: a request accepted in cycle N with the buffer empty SHALL appear on OUT_* in cycle N+1.
REQ-020 The pipeline SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-021 EMPTY: an accept SHALL transition to ONE.
REQ-022 ONE: accept only -> TWO; consume only -> EMPTY; accept and consume together -> ONE, with the new entry replacing the old.
REQ-023 TWO: a consume SHALL transition to ONE; no accept is possible.
REQ-024 IN_READY SHALL be 1 in EMPTY and ONE, and 0 in TWO.
REQ-025 OUT_VALID SHALL be 1 in ONE and TWO.
REQ-026 Results SHALL be delivered in acceptance order, with no loss or duplication.
REQ-027 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_ERR SHALL hold stable.
REQ-028 In TWO, the skid entry SHALL be promoted to the output on the same edge as the consume.
REQ-029 IN_DATA and IN_OP SHALL be ignored when IN_VALID=0 or IN_READY=0.
REQ-030 Extension SHALL be computed combinationally from IN_DATA/IN_OP and registered on accept; no arithmetic beyond bit replication and placement.

Reset
REQ-031 While RST=1 at a rising edge, the state SHALL become EMPTY; OUT_VALID, OUT_DATA and OUT_ERR SHALL become 0; IN_READY SHALL become 1.
REQ-032 Reset SHALL override any simultaneous accept or consume; buffered entries are discarded.
REQ-033 In the first cycle after RST deasserts, the block SHALL accept a request normally.

Configuration
REQ-034 Macro IMM_BRANCH_SHIFT_EN SHALL control mode 3.
REQ-035 The macro SHALL change only the mode-3 behaviour.
REQ-036 With IMM_BRANCH_SHIFT_EN defined, mode 3 SHALL be the branch offset: the sign-extended value (REQ-015) shifted left by 2, with bits [1:0]=0 and upper bits discarded; OUT_ERR=0.
REQ-037 With IMM_BRANCH_SHIFT_EN undefined, mode 3 SHALL yield OUT_DATA=0 and OUT_ERR=1, and the handshake SHALL be unaffected.

Verification
REQ-038 Default parameters, OUT_READY=1: IN_OP=1, IN_DATA=16'h8001 -> next cycle OUT_DATA=32'hFFFF8001, OUT_VALID=1.
REQ-039 OUT_READY=1: back-to-back IN_OP 0,2 with IN_DATA 16'h8001, 16'h1234 -> OUT_DATA 32'h00008001 then 32'h12340000 on consecutive cycles.
REQ-040 OUT_READY=0: three requests presented -> IN_READY=0 after the second; raising OUT_READY delivers the first two in order, then the third.
REQ-041 Mode 3 with IN_DATA=16'hFFFF: macro defined -> 32'hFFFFFFFC, OUT_ERR=0; macro undefined -> 32'h0, OUT_ERR=1.
REQ-042 State TWO, assert RST for one cycle -> OUT_VALID=0, IN_READY=1; the next request emerges alone with 1-cycle latency.
REQ-043 IN_W=8, OUT_W=16, IN_OP=1, IN_DATA=8'h80 -> OUT_DATA=16'hFF80.
